noc_wormhole_allocator: RTL and testbench

//  Output-port allocator for one NoC router output link. Shares the link among N input ports

---
 rtl/noc_alloc_pkg.sv | 15 +
 rtl/noc_wormhole_allocator_if.sv | 27 ++
 rtl/noc_rr_pick.sv | 39 +++
 rtl/noc_wormhole_allocator.sv | 170 +++++++++++++++++
 tb/tb_noc_wormhole_allocator.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_alloc_pkg.sv
// Shared types and helpers for the NoC wormhole output-port allocator.
// Optional lock-timeout feature is enabled by NOC_ALLOC_LOCK_TIMEOUT_EN (see top).
package noc_alloc_pkg;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} alloc_state_e;

   localparam int DEF_CREDITS = 4;
   localparam int DEF_TIMEOUT = 256;

   // Index width that never collapses to zero bits.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/noc_wormhole_allocator_if.sv
// Handshake bundle between the input buffers, the allocator and the output link.
// master = the side that presents flits and returns credits; slave = the allocator.
interface noc_wormhole_allocator_if #(
   parameter int N_IN   = 4,
   parameter int FLIT_W = 64
);
   logic [N_IN-1:0]        in_valid;
   logic [N_IN-1:0]        in_head;
   logic [N_IN-1:0]        in_tail;
   logic [N_IN*FLIT_W-1:0] in_flit;
   logic [N_IN-1:0]        in_ready;
   logic                   out_valid;
   logic [FLIT_W-1:0]      out_flit;
   logic                   out_tail;
   logic                   credit_in;
   logic                   lock_err;

   modport master (
      output in_valid, in_head, in_tail, in_flit, credit_in,
      input  in_ready, out_valid, out_flit, out_tail, lock_err
   );

   modport slave (
      input  in_valid, in_head, in_tail, in_flit, credit_in,
      output in_ready, out_valid, out_flit, out_tail, lock_err
   );
endinterface

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping upward.
// The upper copy of the doubled vector holds all requests, the lower copy only those
// at or above ptr, so a plain lowest-bit scan yields the wrapped winner.
module noc_rr_pick
   import noc_alloc_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   logic [N-1:0]   mask;
   logic [2*N-1:0] dbl;
   logic           found;

   // Masked double-width lowest-set-bit scan.
   always_comb begin
      mask  = '0;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i >= int'(ptr));
      end
      dbl = {req, req & mask};
      for (int i = 0; i < 2*N; i++) begin
         if (!found && dbl[i]) begin
            found          = 1'b1;
            grant[i % N]   = 1'b1;
            idx            = IW'(i % N);
         end
      end
   end

endmodule

// File: rtl/noc_wormhole_allocator.sv
// Output-port allocator: packet-granular round-robin with wormhole lock,
// credit-gated forwarding and a one-cycle registered link output.
// Optional feature macro: NOC_ALLOC_LOCK_TIMEOUT_EN (abandons a stalled lock
// after TIMEOUT idle cycles and raises sticky lock_err).
module noc_wormhole_allocator
   import noc_alloc_pkg::*;
#(
   parameter int N_IN    = 4,
   parameter int FLIT_W  = 64,
   parameter int CREDITS = DEF_CREDITS,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input logic                     clk,
   input logic                     rst_n,
   noc_wormhole_allocator_if.slave bus
);

   localparam int IW = idx_w(N_IN);
   localparam int CW = $clog2(CREDITS + 1);

   alloc_state_e             state;
   logic [IW-1:0]            owner;
   logic [IW-1:0]            rr_ptr;
   logic [CW-1:0]            credits;
   logic [N_IN-1:0]          cand;
   logic [N_IN-1:0]          pick_grant;
   logic [IW-1:0]            pick_idx;
   logic [N_IN-1:0]          grant;
   logic [N_IN-1:0]          ready;
   logic [IW-1:0]            sel;
   logic                     can_send;
   logic                     fire;
   logic                     sel_tail;
   logic [FLIT_W-1:0]        sel_flit;
   logic                     timeout_hit;
   logic                     vld_p1;
   logic                     tail_p1;
   logic [FLIT_W-1:0]        flit_p1;

   function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] i);
      return (int'(i) == N_IN - 1) ? '0 : i + IW'(1);
   endfunction

   assign cand = bus.in_valid & bus.in_head;

   noc_rr_pick #(.N(N_IN), .IW(IW)) u_pick (
      .req   (cand),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   // Grant selection: round-robin winner when idle, the lock owner otherwise.
   always_comb begin
      grant = '0;
      sel   = pick_idx;
      if (state == IDLE) begin
         grant = pick_grant;
      end else begin
         grant[owner] = 1'b1;
         sel          = owner;
      end
   end

   assign can_send     = (credits != '0);
   assign ready        = grant & bus.in_valid & {N_IN{can_send}};
   assign bus.in_ready = ready;
   assign fire         = |(bus.in_valid & ready);
   assign sel_flit     = bus.in_flit[int'(sel)*FLIT_W +: FLIT_W];
   assign sel_tail     = bus.in_tail[sel];

   // Allocation FSM: lock on a multi-flit head, release on tail or timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fire) begin
                  if (sel_tail) begin
                     rr_ptr <= ptr_after(sel);
                  end else begin
                     owner <= sel;
                     state <= LOCKED;
                  end
               end
            end
            LOCKED: begin
               if ((fire && sel_tail) || timeout_hit) begin
                  rr_ptr <= ptr_after(owner);
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Downstream credit counter; a simultaneous send and return cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits <= CW'(CREDITS);
      end else if (fire && !bus.credit_in) begin
         credits <= credits - CW'(1);
      end else if (bus.credit_in && !fire && credits != CW'(CREDITS)) begin
         credits <= credits + CW'(1);
      end
   end

   // ---- stage p1: registered link output; payload holds when nothing fires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         tail_p1 <= 1'b0;
         flit_p1 <= '0;
      end else begin
         vld_p1 <= fire;
         if (fire) begin
            tail_p1 <= sel_tail;
            flit_p1 <= sel_flit;
         end
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_tail  = tail_p1;
   assign bus.out_flit  = flit_p1;

`ifdef NOC_ALLOC_LOCK_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] idle_cnt;
   logic          owner_stall;
   logic          lock_err_r;

   assign owner_stall = (state == LOCKED) && !bus.in_valid[owner];
   assign timeout_hit = owner_stall && (idle_cnt == TW'(TIMEOUT - 1));

   // Idle counter inside a lock; reaching TIMEOUT abandons the packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt   <= '0;
         lock_err_r <= 1'b0;
      end else begin
         if (!owner_stall || timeout_hit) begin
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + TW'(1);
         end
         if (timeout_hit) begin
            lock_err_r <= 1'b1;
         end
      end
   end

   assign bus.lock_err = lock_err_r;
`else
   assign timeout_hit  = 1'b0;
   assign bus.lock_err = 1'b0;
`endif

   credit_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.credit_in && credits == CW'(CREDITS)));

   param_sanity_a: assert property (@(posedge clk) disable iff (!rst_n)
      (N_IN >= 2) && (CREDITS >= 1) && (TIMEOUT >= 1));

endmodule

// File: tb/tb_noc_wormhole_allocator.sv
// Directed bench for noc_wormhole_allocator: table-driven arbitration/credit
// vectors plus hand-written sequences for fairness, credit stall, reset and lock timeout.
module tb_noc_wormhole_allocator;
   import noc_alloc_pkg::*;

   localparam int N  = 4;
   localparam int FW = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   noc_wormhole_allocator_if #(.N_IN(N), .FLIT_W(FW)) bus  ();
   noc_wormhole_allocator_if #(.N_IN(N), .FLIT_W(FW)) bus2 ();

   noc_wormhole_allocator #(.N_IN(N), .FLIT_W(FW), .CREDITS(4), .TIMEOUT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   noc_wormhole_allocator #(.N_IN(N), .FLIT_W(FW), .CREDITS(2), .TIMEOUT(8)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   typedef struct packed {
      logic [3:0]  v;
      logic [3:0]  h;
      logic [3:0]  t;
      logic        c;
      logic [7:0]  tag;
      logic [3:0]  rdy;
      logic        ov;
      logic        ot;
      logic [15:0] of;
   } vec_t;

   vec_t vecs [18];
   int   total  = 0;
   int   passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [FW-1:0] fl(input int i, input int tag);
      return FW'(i * 4096 + tag);
   endfunction

   function automatic logic [N*FW-1:0] pack(input int tag);
      logic [N*FW-1:0] p;
      p = '0;
      for (int i = 0; i < N; i++) p[i*FW +: FW] = fl(i, tag);
      return p;
   endfunction

   task automatic drv(input logic [3:0] v, input logic [3:0] h, input logic [3:0] t,
                      input logic c, input int tag);
      bus.in_valid  = v;
      bus.in_head   = h;
      bus.in_tail   = t;
      bus.credit_in = c;
      bus.in_flit   = pack(tag);
   endtask

   task automatic drv2(input logic [3:0] v, input logic [3:0] h, input logic [3:0] t,
                       input logic c, input int tag);
      bus2.in_valid  = v;
      bus2.in_head   = h;
      bus2.in_tail   = t;
      bus2.credit_in = c;
      bus2.in_flit   = pack(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      drv(4'b0, 4'b0, 4'b0, 1'b0, 0);
      drv2(4'b0, 4'b0, 4'b0, 1'b0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int cnt [4];
      int bad;
      int fires;

      drv(4'b0, 4'b0, 4'b0, 1'b0, 0);
      drv2(4'b0, 4'b0, 4'b0, 1'b0, 0);

      //           v       h       t       c     tag    rdy     ov    ot    of
      vecs[0]  = '{4'b0101,4'b0101,4'b0000,1'b0,8'h01,4'b0001,1'b0,1'b0,16'h0000};
      vecs[1]  = '{4'b0101,4'b0100,4'b0000,1'b1,8'h02,4'b0001,1'b1,1'b0,16'h0001};
      vecs[2]  = '{4'b0101,4'b0100,4'b0001,1'b1,8'h03,4'b0001,1'b1,1'b0,16'h0002};
      vecs[3]  = '{4'b0100,4'b0100,4'b0000,1'b1,8'h04,4'b0100,1'b1,1'b1,16'h0003};
      vecs[4]  = '{4'b0101,4'b0001,4'b0000,1'b1,8'h05,4'b0100,1'b1,1'b0,16'h2004};
      vecs[5]  = '{4'b0101,4'b0001,4'b0100,1'b0,8'h06,4'b0100,1'b1,1'b0,16'h2005};
      vecs[6]  = '{4'b0000,4'b0000,4'b0000,1'b0,8'h07,4'b0000,1'b1,1'b1,16'h2006};
      vecs[7]  = '{4'b0010,4'b0000,4'b0000,1'b0,8'h08,4'b0000,1'b0,1'b0,16'h2006};
      vecs[8]  = '{4'b0010,4'b0010,4'b0010,1'b0,8'h09,4'b0010,1'b0,1'b0,16'h2006};
      vecs[9]  = '{4'b1111,4'b1111,4'b1111,1'b0,8'h0A,4'b0100,1'b1,1'b1,16'h1009};
      vecs[10] = '{4'b1111,4'b1111,4'b1111,1'b0,8'h0B,4'b0000,1'b1,1'b1,16'h200A};
      vecs[11] = '{4'b1111,4'b1111,4'b1111,1'b1,8'h0C,4'b0000,1'b0,1'b0,16'h200A};
      vecs[12] = '{4'b1111,4'b1111,4'b1111,1'b0,8'h0D,4'b1000,1'b0,1'b0,16'h200A};
      vecs[13] = '{4'b1111,4'b1111,4'b1111,1'b0,8'h0E,4'b0000,1'b1,1'b1,16'h300D};
      vecs[14] = '{4'b1111,4'b1111,4'b1111,1'b1,8'h0F,4'b0000,1'b0,1'b0,16'h300D};
      vecs[15] = '{4'b1111,4'b1111,4'b1111,1'b1,8'h10,4'b0001,1'b0,1'b0,16'h300D};
      vecs[16] = '{4'b1111,4'b1111,4'b1111,1'b0,8'h11,4'b0010,1'b1,1'b1,16'h0010};
      vecs[17] = '{4'b1111,4'b1111,4'b1111,1'b0,8'h12,4'b0000,1'b1,1'b1,16'h1011};

      // Reset state
      do_reset();
      #1;
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst out_flit",  32'(bus.out_flit),  32'd0);
      chk("rst out_tail",  32'(bus.out_tail),  32'd0);
      chk("rst lock_err",  32'(bus.lock_err),  32'd0);
      chk("rst in_ready",  32'(bus.in_ready),  32'd0);
      chk("rst credits",   32'(dut.credits),   32'd4);

      // Packet ordering, protocol error, credit block and credit/fire overlap
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         drv(vecs[k].v, vecs[k].h, vecs[k].t, vecs[k].c, int'(vecs[k].tag));
         #1;
         chk($sformatf("vec%0d in_ready", k),  32'(bus.in_ready),  32'(vecs[k].rdy));
         chk($sformatf("vec%0d out_valid", k), 32'(bus.out_valid), 32'(vecs[k].ov));
         chk($sformatf("vec%0d out_flit", k),  32'(bus.out_flit),  32'(vecs[k].of));
         if (vecs[k].ov) chk($sformatf("vec%0d out_tail", k), 32'(bus.out_tail), 32'(vecs[k].ot));
      end

      // Fairness: four continuous single-flit streams
      do_reset();
      bad = 0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         drv(4'hF, 4'hF, 4'hF, k > 0, k);
         #1;
         if (bus.in_ready !== 4'(1 << (k % 4))) bad++;
         if (k > 0 && (bus.out_valid !== 1'b1 || bus.out_flit !== fl((k - 1) % 4, k - 1))) bad++;
         for (int i = 0; i < 4; i++) if (bus.in_ready[i]) cnt[i]++;
      end
      chk("rr order errors", 32'(bad), 32'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("rr grants in%0d", i), 32'(cnt[i]), 32'd25);
      chk("rr lock_err", 32'(bus.lock_err), 32'd0);

      // Asynchronous reset in the middle of a packet
      do_reset();
      @(negedge clk);
      drv(4'b0001, 4'b0001, 4'b0000, 1'b0, 8'h21);
      #1 chk("mid head ready", 32'(bus.in_ready), 32'b0001);
      @(negedge clk);
      drv(4'b0001, 4'b0000, 4'b0000, 1'b0, 8'h22);
      #1 chk("mid body ready", 32'(bus.in_ready), 32'b0001);
      chk("mid out_valid", 32'(bus.out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid rst out_flit",  32'(bus.out_flit),  32'd0);
      chk("mid rst out_tail",  32'(bus.out_tail),  32'd0);
      chk("mid rst credits",   32'(dut.credits),   32'd4);
      chk("mid rst state",     32'(dut.state),     32'(IDLE));
      chk("mid rst orphan",    32'(bus.in_ready),  32'd0);
      @(negedge clk);
      chk("mid rst no emit", 32'(bus.out_valid), 32'd0);
      rst_n = 1'b1;
      drv(4'b1001, 4'b1000, 4'b0000, 1'b0, 8'h23);
      #1 chk("post rst in3 head", 32'(bus.in_ready), 32'b1000);
      @(negedge clk);
      drv(4'b1001, 4'b0000, 4'b1000, 1'b0, 8'h24);
      #1 chk("post rst in3 tail", 32'(bus.in_ready), 32'b1000);
      chk("post rst flit head", 32'(bus.out_flit), 32'(fl(3, 8'h23)));
      @(negedge clk);
      drv(4'b0001, 4'b0000, 4'b0000, 1'b0, 8'h25);
      #1 chk("orphan body", 32'(bus.in_ready), 32'd0);
      chk("post rst flit tail", 32'(bus.out_flit), 32'(fl(3, 8'h24)));
      chk("post rst tail mark", 32'(bus.out_tail), 32'd1);

      // Credit exhaustion with CREDITS=2 on a 5-flit packet
      do_reset();
      fires = 0;
      @(negedge clk);
      drv2(4'b0001, 4'b0001, 4'b0000, 1'b0, 8'h31);
      #1 chk("cr head ready", 32'(bus2.in_ready), 32'b0001);
      fires += int'(|(bus2.in_valid & bus2.in_ready));
      @(negedge clk);
      drv2(4'b0001, 4'b0000, 4'b0000, 1'b0, 8'h32);
      #1 chk("cr body1 ready", 32'(bus2.in_ready), 32'b0001);
      chk("cr head out", 32'(bus2.out_flit), 32'(fl(0, 8'h31)));
      fires += int'(|(bus2.in_valid & bus2.in_ready));
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drv2(4'b0101, 4'b0100, 4'b0000, 1'b0, 8'h33);
         #1;
         if (bus2.in_ready !== 4'b0000) bad++;
         fires += int'(|(bus2.in_valid & bus2.in_ready));
      end
      chk("cr blocked cycles", 32'(bad), 32'd0);
      @(negedge clk);
      drv2(4'b0101, 4'b0100, 4'b0000, 1'b1, 8'h33);
      #1 chk("cr return cycle", 32'(bus2.in_ready), 32'b0000);
      fires += int'(|(bus2.in_valid & bus2.in_ready));
      @(negedge clk);
      drv2(4'b0101, 4'b0100, 4'b0000, 1'b0, 8'h34);
      #1 chk("cr released", 32'(bus2.in_ready), 32'b0001);
      fires += int'(|(bus2.in_valid & bus2.in_ready));
      @(negedge clk);
      drv2(4'b0101, 4'b0100, 4'b0000, 1'b0, 8'h35);
      #1 chk("cr reblocked", 32'(bus2.in_ready), 32'b0000);
      chk("cr released flit", 32'(bus2.out_flit), 32'(fl(0, 8'h34)));
      fires += int'(|(bus2.in_valid & bus2.in_ready));
      chk("cr total fires", 32'(fires), 32'd3);
      chk("cr lock held", 32'(dut2.state), 32'(LOCKED));
      drv2(4'b0, 4'b0, 4'b0, 1'b0, 0);

      // Owner stalls inside a locked packet
      do_reset();
      @(negedge clk);
      drv(4'b0001, 4'b0001, 4'b0000, 1'b0, 8'h41);
      #1 chk("to head ready", 32'(bus.in_ready), 32'b0001);
      bad = 0;
`ifdef NOC_ALLOC_LOCK_TIMEOUT_EN
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         drv(4'b0010, 4'b0010, 4'b0010, 1'b0, 8'h42);
         #1;
         if (bus.in_ready !== 4'b0000 || bus.lock_err !== 1'b0 || dut.state !== LOCKED) bad++;
      end
      chk("to stall window", 32'(bad), 32'd0);
      @(negedge clk);
      drv(4'b0010, 4'b0010, 4'b0010, 1'b0, 8'h43);
      #1 chk("to lock_err", 32'(bus.lock_err), 32'd1);
      chk("to state", 32'(dut.state), 32'(IDLE));
      chk("to next head", 32'(bus.in_ready), 32'b0010);
      @(negedge clk);
      drv(4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h44);
      #1 chk("to sticky", 32'(bus.lock_err), 32'd1);
`else
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         drv(4'b0010, 4'b0010, 4'b0010, 1'b0, 8'h42);
         #1;
         if (bus.in_ready !== 4'b0000 || bus.lock_err !== 1'b0 || dut.state !== LOCKED) bad++;
      end
      chk("stall lock held", 32'(bad), 32'd0);
      @(negedge clk);
      drv(4'b0011, 4'b0010, 4'b0011, 1'b0, 8'h43);
      #1 chk("stall owner tail", 32'(bus.in_ready), 32'b0001);
      @(negedge clk);
      drv(4'b0010, 4'b0010, 4'b0010, 1'b0, 8'h44);
      #1 chk("stall next head", 32'(bus.in_ready), 32'b0010);
      chk("stall lock_err", 32'(bus.lock_err), 32'd0);
`endif

      @(negedge clk);
      drv(4'b0, 4'b0, 4'b0, 1'b0, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
